dot_scan_controller: RTL and testbench

Sequencer and access arbiter for the dot_sequencer memory/dot array. Raster-scans row_select/col_select over a programmable window with a programmable dwell per dot, and samples firing_bit/firing_data once per dot into a registered fire strobe. Host writes to mem, mem_dot and mem_sel are granted only while no scan is active (IDLE) or in the inter-frame gap, so tables never change mid-frame.

---
 rtl/dot_scan_pkg.sv | 20 ++
 rtl/dot_scan_wr_port.sv | 60 ++++++
 rtl/dot_scan_controller.sv | 202 ++++++++++++++++++++
 tb/tb_dot_scan_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_scan_pkg.sv
// Shared types for the dot scan controller: FSM encoding and host write kinds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dot_scan_pkg;

   // Scan sequencer states; IDLE and GAP are the only states that accept host writes.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DWELL   = 2'd1,
      ADVANCE = 2'd2,
      GAP     = 2'd3
   } scan_state_t;

   // host_wr_kind encodings; the remaining code is reserved and only acknowledged.
   localparam logic [1:0] KIND_MEM  = 2'd0;
   localparam logic [1:0] KIND_DOT  = 2'd1;
   localparam logic [1:0] KIND_SEL  = 2'd2;
   localparam logic [1:0] KIND_RSVD = 2'd3;

endpackage

// File: rtl/dot_scan_wr_port.sv
// Host write port: registers one request and drives a one-cycle active-low strobe plus ack.
// Latency: strobe and ack one cycle after the request is sampled inside the write window.
// Backpressure: requests outside the window, or in the ack cycle itself, are not taken (max one write per 2 cycles).
module dot_scan_wr_port
   import dot_scan_pkg::*;
#(
   parameter int MEM_ADDRESS_LENGTH = 6
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wr_window,
   input  logic                          host_wr_req,
   input  logic [1:0]                    host_wr_kind,
   input  logic [MEM_ADDRESS_LENGTH-1:0] host_wr_addr,
   input  logic [2:0]                    host_mask_sel,
   input  logic [15:0]                   host_wr_data,
   output logic                          host_wr_ack,
   output logic                          mem_write_n,
   output logic                          mem_dot_write_n,
   output logic                          mem_sel_write_n,
   output logic [MEM_ADDRESS_LENGTH-1:0] mem_address,
   output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address,
   output logic [2:0]                    mask_select,
   output logic [15:0]                   data_in
);

   logic capture;

   // The ack cycle blocks a second capture of the same still-asserted request.
   assign capture = wr_window & host_wr_req & ~host_wr_ack;

   // Register the write and fire exactly one strobe for its kind; reset drops anything pending.
   always_ff @(posedge clock) begin
      if (reset) begin
         host_wr_ack         <= 1'b0;
         mem_write_n         <= 1'b1;
         mem_dot_write_n     <= 1'b1;
         mem_sel_write_n     <= 1'b1;
         mem_address         <= '0;
         mem_sel_col_address <= '0;
         mask_select         <= '0;
         data_in             <= '0;
      end else begin
         host_wr_ack     <= capture;
         mem_write_n     <= ~(capture && host_wr_kind == KIND_MEM);
         mem_dot_write_n <= ~(capture && host_wr_kind == KIND_DOT);
         mem_sel_write_n <= ~(capture && host_wr_kind == KIND_SEL);
         if (capture) begin
            if (host_wr_kind == KIND_SEL) begin
               mem_sel_col_address <= host_wr_addr;
            end else begin
               mem_address <= host_wr_addr;
            end
            mask_select <= host_mask_sel;
            data_in     <= host_wr_data;
         end
      end
   end

endmodule

// File: rtl/dot_scan_controller.sv
// Dot array scanner: raster (or serpentine with DOT_SCAN_SNAKE_EN) over a window, one fire sample per dot.
// Latency: dot period dwell+1 cycles; fire_strobe one cycle after the sample; write ack one cycle after req.
// Backpressure: host writes wait for IDLE or GAP; GAP stretches while a write is requested or in flight.
module dot_scan_controller
   import dot_scan_pkg::*;
#(
   parameter int MEM_LENGTH         = 48,
   parameter int MEM_ADDRESS_LENGTH = 6,
   parameter int DWELL_WIDTH        = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          continuous,
   input  logic                          row_col_sel_cfg,
   input  logic [MEM_ADDRESS_LENGTH-1:0] row_last,
   input  logic [MEM_ADDRESS_LENGTH-1:0] col_last,
   input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
   input  logic                          firing_bit,
   input  logic                          firing_data,
   output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
   output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
   output logic                          row_col_select,
   output logic                          fire_strobe,
   output logic                          fire_hit,
   output logic                          busy,
   output logic                          frame_done,
   output logic [15:0]                   frame_count,
   input  logic                          host_wr_req,
   input  logic [1:0]                    host_wr_kind,
   input  logic [MEM_ADDRESS_LENGTH-1:0] host_wr_addr,
   input  logic [2:0]                    host_mask_sel,
   input  logic [15:0]                   host_wr_data,
   output logic                          host_wr_ack,
   output logic                          mem_write_n,
   output logic                          mem_dot_write_n,
   output logic                          mem_sel_write_n,
   output logic [MEM_ADDRESS_LENGTH-1:0] mem_address,
   output logic [MEM_ADDRESS_LENGTH-1:0] mem_sel_col_address,
   output logic [2:0]                    mask_select,
   output logic [15:0]                   data_in
);

   localparam int AW = MEM_ADDRESS_LENGTH;
   localparam int DW = DWELL_WIDTH;
   localparam logic [AW-1:0] LAST_IDX = AW'(MEM_LENGTH - 1);

   scan_state_t   state, state_nxt;
   logic [AW-1:0] row, row_nxt, col, col_nxt;
   logic [AW-1:0] row_last_q, col_last_q, row_last_clamp, col_last_clamp;
   logic [AW-1:0] row_end, col_step, col_wrap;
   logic [DW-1:0] dwell_cnt, dwell_cnt_nxt, dwell_load;
   logic          win_load, sample, frame_end, wr_window;
   logic          at_row_end, at_frame_end;

   assign row_last_clamp = (row_last > LAST_IDX) ? LAST_IDX : row_last;
   assign col_last_clamp = (col_last > LAST_IDX) ? LAST_IDX : col_last;
   assign dwell_load     = (dwell_cycles == '0) ? DW'(1) : dwell_cycles;

`ifdef DOT_SCAN_SNAKE_EN
   // Odd rows run right-to-left, so a row ends at column 0 and the next row starts where this one ended.
   assign row_end  = row[0] ? '0 : col_last_q;
   assign col_step = row[0] ? col - 1'b1 : col + 1'b1;
   assign col_wrap = col;
`else
   assign row_end  = col_last_q;
   assign col_step = col + 1'b1;
   assign col_wrap = '0;
`endif

   assign at_row_end   = (col == row_end);
   assign at_frame_end = at_row_end && (row == row_last_q);

   assign row_select     = row;
   assign col_select     = col;
   assign busy           = (state != IDLE);
   assign row_col_select = busy ? row_col_sel_cfg : 1'b0;

   // Next-state, scan position and dwell counter; write window only opens between frames.
   always_comb begin
      state_nxt     = state;
      row_nxt       = row;
      col_nxt       = col;
      dwell_cnt_nxt = dwell_cnt;
      win_load      = 1'b0;
      sample        = 1'b0;
      frame_end     = 1'b0;
      wr_window     = 1'b0;
      case (state)
         IDLE: begin
            wr_window = ~start;
            if (start) begin
               row_nxt       = '0;
               col_nxt       = '0;
               dwell_cnt_nxt = dwell_load;
               win_load      = 1'b1;
               state_nxt     = DWELL;
            end
         end
         DWELL: begin
            if (stop) begin
               row_nxt   = '0;
               col_nxt   = '0;
               state_nxt = IDLE;
            end else if (dwell_cnt == DW'(1)) begin
               sample    = 1'b1;
               state_nxt = ADVANCE;
            end else begin
               dwell_cnt_nxt = dwell_cnt - 1'b1;
            end
         end
         ADVANCE: begin
            if (stop) begin
               row_nxt   = '0;
               col_nxt   = '0;
               state_nxt = IDLE;
            end else if (at_frame_end) begin
               row_nxt   = '0;
               col_nxt   = '0;
               frame_end = 1'b1;
               state_nxt = GAP;
            end else begin
               if (at_row_end) begin
                  row_nxt = row + 1'b1;
                  col_nxt = col_wrap;
               end else begin
                  col_nxt = col_step;
               end
               dwell_cnt_nxt = dwell_load;
               state_nxt     = DWELL;
            end
         end
         GAP: begin
            wr_window = 1'b1;
            if (!host_wr_req && !host_wr_ack) begin
               if (continuous && !stop) begin
                  dwell_cnt_nxt = dwell_load;
                  win_load      = 1'b1;
                  state_nxt     = DWELL;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, window latch and registered fire/frame reporting.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         row         <= '0;
         col         <= '0;
         row_last_q  <= '0;
         col_last_q  <= '0;
         dwell_cnt   <= '0;
         fire_strobe <= 1'b0;
         fire_hit    <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         row         <= row_nxt;
         col         <= col_nxt;
         dwell_cnt   <= dwell_cnt_nxt;
         fire_strobe <= sample;
         fire_hit    <= sample & firing_bit & firing_data;
         frame_done  <= frame_end;
         if (win_load) begin
            row_last_q <= row_last_clamp;
            col_last_q <= col_last_clamp;
         end
         if (frame_end) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

   dot_scan_wr_port #(
      .MEM_ADDRESS_LENGTH (MEM_ADDRESS_LENGTH)
   ) u_wr_port (
      .clock               (clock),
      .reset               (reset),
      .wr_window           (wr_window),
      .host_wr_req         (host_wr_req),
      .host_wr_kind        (host_wr_kind),
      .host_wr_addr        (host_wr_addr),
      .host_mask_sel       (host_mask_sel),
      .host_wr_data        (host_wr_data),
      .host_wr_ack         (host_wr_ack),
      .mem_write_n         (mem_write_n),
      .mem_dot_write_n     (mem_dot_write_n),
      .mem_sel_write_n     (mem_sel_write_n),
      .mem_address         (mem_address),
      .mem_sel_col_address (mem_sel_col_address),
      .mask_select         (mask_select),
      .data_in             (data_in)
   );

endmodule

// File: tb/tb_dot_scan_controller.sv
// Bench for dot_scan_controller: directed scans and host writes, scoreboarded fire/frame/write events.
// Expected events carry the cycle they must appear in; a negedge monitor pops and compares them.
// Also honours DOT_SCAN_SNAKE_EN for the expected column order.
module tb_dot_scan_controller;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int ML = 48;

   logic          clock = 1'b0;
   logic          reset, start, stop, continuous, row_col_sel_cfg;
   logic [AW-1:0] row_last, col_last;
   logic [DW-1:0] dwell_cycles;
   logic          firing_bit, firing_data;
   logic [AW-1:0] row_select, col_select;
   logic          row_col_select, fire_strobe, fire_hit, busy, frame_done;
   logic [15:0]   frame_count;
   logic          host_wr_req;
   logic [1:0]    host_wr_kind;
   logic [AW-1:0] host_wr_addr;
   logic [2:0]    host_mask_sel;
   logic [15:0]   host_wr_data;
   logic          host_wr_ack, mem_write_n, mem_dot_write_n, mem_sel_write_n;
   logic [AW-1:0] mem_address, mem_sel_col_address;
   logic [2:0]    mask_select;
   logic [15:0]   data_in;

   typedef struct {int cyc; int row; int col; logic hit;} fire_exp_t;
   typedef struct {int cyc; logic [15:0] count;} frame_exp_t;
   typedef struct {int cyc; logic [1:0] kind; logic [5:0] addr; logic [2:0] mask; logic [15:0] data;} wr_exp_t;

   fire_exp_t  fire_q[$];
   frame_exp_t frame_q[$];
   wr_exp_t    wr_q[$];

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_frames = 16'd0;
   int          s;

   dot_scan_controller dut (
      .clock (clock), .reset (reset), .start (start), .stop (stop),
      .continuous (continuous), .row_col_sel_cfg (row_col_sel_cfg),
      .row_last (row_last), .col_last (col_last), .dwell_cycles (dwell_cycles),
      .firing_bit (firing_bit), .firing_data (firing_data),
      .row_select (row_select), .col_select (col_select), .row_col_select (row_col_select),
      .fire_strobe (fire_strobe), .fire_hit (fire_hit), .busy (busy),
      .frame_done (frame_done), .frame_count (frame_count),
      .host_wr_req (host_wr_req), .host_wr_kind (host_wr_kind), .host_wr_addr (host_wr_addr),
      .host_mask_sel (host_mask_sel), .host_wr_data (host_wr_data), .host_wr_ack (host_wr_ack),
      .mem_write_n (mem_write_n), .mem_dot_write_n (mem_dot_write_n), .mem_sel_write_n (mem_sel_write_n),
      .mem_address (mem_address), .mem_sel_col_address (mem_sel_col_address),
      .mask_select (mask_select), .data_in (data_in)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Stand-in for dot_sequencer: a fixed firing pattern over the selected dot.
   always_comb begin
      firing_bit  = (row_select[0] == col_select[0]);
      firing_data = (col_select != 6'd2);
   end

   function automatic logic exp_hit(input int r, input int c);
      return ((r % 2) == (c % 2)) && (c != 2);
   endfunction

   function automatic logic [2:0] exp_strobes(input logic [1:0] k);
      case (k)
         2'd0:    return 3'b011;
         2'd1:    return 3'b101;
         2'd2:    return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic extra(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected DUT output at cycle %0d, none expected", name, cyc);
   endtask

   // Queue the fire events (and frame_done unless truncated) of one frame starting at edge t0.
   task automatic push_scan(input int t0, input int rl, input int cl, input int d, input int max_dots);
      int de, rle, cle, n, k, c;
      de  = (d == 0) ? 1 : d;
      rle = (rl > ML - 1) ? ML - 1 : rl;
      cle = (cl > ML - 1) ? ML - 1 : cl;
      n   = (rle + 1) * (cle + 1);
      k   = 0;
      for (int r = 0; r <= rle; r++) begin
         for (int j = 0; j <= cle; j++) begin
            c = j;
`ifdef DOT_SCAN_SNAKE_EN
            if (r % 2 == 1) c = cle - j;
`endif
            if (max_dots < 0 || k < max_dots)
               fire_q.push_back('{t0 + de + k * (de + 1), r, c, exp_hit(r, c)});
            k++;
         end
      end
      if (max_dots < 0) begin
         exp_frames = exp_frames + 16'd1;
         frame_q.push_back('{t0 + n * (de + 1), exp_frames});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clock); #1;
      end
   endtask

   // Requester: hold req until ack is seen, keep it one more cycle, then release.
   task automatic issue_write(input logic [1:0] kind, input logic [5:0] addr, input logic [2:0] mask,
                              input logic [15:0] data, input int exp_cyc);
      int waited;
      waited = 0;
      wr_q.push_back('{exp_cyc, kind, addr, mask, data});
      host_wr_kind  = kind;
      host_wr_addr  = addr;
      host_mask_sel = mask;
      host_wr_data  = data;
      host_wr_req   = 1'b1;
      do begin
         @(posedge clock); #1;
         waited++;
      end while (!host_wr_ack && waited < 60);
      if (!host_wr_ack) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wr_ack_timeout: no ack after %0d cycles, expected at cycle %0d", waited, exp_cyc);
      end
      @(posedge clock); #1;
      host_wr_req = 1'b0;
   endtask

   // Monitor: every fire, frame and write event must match the head of its queue.
   always @(negedge clock) begin
      if (!reset) begin
         if (fire_strobe) begin
            if (fire_q.size() == 0) extra("fire_extra");
            else begin
               fire_exp_t fe;
               fe = fire_q.pop_front();
               check("fire_cycle", cyc, fe.cyc);
               check("fire_row", row_select, fe.row);
               check("fire_col", col_select, fe.col);
               check("fire_hit", fire_hit, fe.hit);
            end
         end
         if (frame_done) begin
            if (frame_q.size() == 0) extra("frame_extra");
            else begin
               frame_exp_t me;
               me = frame_q.pop_front();
               check("frame_cycle", cyc, me.cyc);
               check("frame_count", frame_count, me.count);
            end
         end
         if (host_wr_ack || !mem_write_n || !mem_dot_write_n || !mem_sel_write_n) begin
            if (wr_q.size() == 0) extra("wr_extra");
            else begin
               wr_exp_t we;
               we = wr_q.pop_front();
               check("wr_cycle", cyc, we.cyc);
               check("wr_ack", host_wr_ack, 1);
               check("wr_strobes", {mem_write_n, mem_dot_write_n, mem_sel_write_n}, exp_strobes(we.kind));
               if (we.kind == 2'd0) check("wr_mem_address", mem_address, we.addr);
               if (we.kind == 2'd2) check("wr_sel_address", mem_sel_col_address, we.addr);
               if (we.kind != 2'd3) begin
                  check("wr_mask", mask_select, we.mask);
                  check("wr_data", data_in, we.data);
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; row_col_sel_cfg = 1'b1;
      row_last = '0; col_last = '0; dwell_cycles = 16'd1;
      host_wr_req = 1'b0; host_wr_kind = '0; host_wr_addr = '0; host_mask_sel = '0; host_wr_data = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_row", row_select, 0);
      check("rst_col", col_select, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_rcs", row_col_select, 0);
      check("rst_strobes", {mem_write_n, mem_dot_write_n, mem_sel_write_n}, 3'b111);
      check("rst_flags", {fire_strobe, fire_hit, frame_done, host_wr_ack, busy}, 5'b0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Host writes while idle, back to back.
      issue_write(2'd0, 6'd5, 3'd1, 16'hA5A5, cyc + 1);
      issue_write(2'd1, 6'd7, 3'd2, 16'h0F0F, cyc + 1);
      issue_write(2'd2, 6'd33, 3'd6, 16'h1234, cyc + 1);
      issue_write(2'd3, 6'd1, 3'd0, 16'hFFFF, cyc + 1);
      repeat (2) @(posedge clock);
      #1;

      // 2x3 window, dwell 3: six dots four cycles apart, single frame.
      row_last = 6'd1; col_last = 6'd2; dwell_cycles = 16'd3;
      s = cyc + 1;
      push_scan(s, 1, 2, 3, -1);
      pulse_start();
      wait_to(s + 2);
      check("busy_scan", busy, 1);
      check("rcs_scan", row_col_select, 1);
      wait_to(s + 30);
      check("busy_after_frame", busy, 0);
      check("rcs_idle", row_col_select, 0);
      check("frame_count_1", frame_count, exp_frames);
      check("row_after_frame", row_select, 0);

      // dwell 0 acts as 1; col_last 63 clamps to 47.
      row_last = 6'd0; col_last = 6'd63; dwell_cycles = 16'd0;
      s = cyc + 1;
      push_scan(s, 0, 63, 0, -1);
      pulse_start();
      wait_to(s + 100);
      check("frame_count_clamp", frame_count, exp_frames);

      // start and write in the same idle cycle: the write lands in the gap.
      row_last = 6'd0; col_last = 6'd0; dwell_cycles = 16'd1;
      s = cyc + 1;
      push_scan(s, 0, 0, 1, -1);
      fork
         pulse_start();
         issue_write(2'd0, 6'd9, 3'd3, 16'hBEEF, s + 3);
      join
      wait_to(s + 8);
      check("busy_after_start_wr", busy, 0);

      // Write raised mid-dwell in continuous mode: held to the gap, gap stretched, next frame after it.
      row_last = 6'd0; col_last = 6'd1; dwell_cycles = 16'd2; continuous = 1'b1;
      s = cyc + 1;
      push_scan(s, 0, 1, 2, -1);
      push_scan(s + 9, 0, 1, 2, -1);
      pulse_start();
      @(posedge clock); #1;
      issue_write(2'd2, 6'd12, 3'd4, 16'h5A5A, s + 7);
      wait_to(s + 10);
      continuous = 1'b0;
      wait_to(s + 20);
      check("busy_after_gap_wr", busy, 0);
      check("frame_count_gap_wr", frame_count, exp_frames);

      // Reset in the middle of a dot clears position and count.
      row_last = 6'd1; col_last = 6'd1; dwell_cycles = 16'd20;
      s = cyc + 1;
      push_scan(s, 1, 1, 20, 1);
      pulse_start();
      wait_to(s + 25);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_frames = 16'd0;
      check("midrst_busy", busy, 0);
      check("midrst_col", col_select, 0);
      check("midrst_frame_count", frame_count, 0);

      // Continuous 2x2 scan, three frames, stop on the last dwell cycle of a dot in frame four.
      row_last = 6'd1; col_last = 6'd1; dwell_cycles = 16'd1; continuous = 1'b1;
      s = cyc + 1;
      push_scan(s, 1, 1, 1, -1);
      push_scan(s + 9, 1, 1, 1, -1);
      push_scan(s + 18, 1, 1, 1, -1);
      push_scan(s + 27, 1, 1, 1, 2);
      pulse_start();
      wait_to(s + 31);
      stop = 1'b1;
      @(posedge clock); #1;
      stop = 1'b0;
      continuous = 1'b0;
      check("stop_row", row_select, 0);
      check("stop_col", col_select, 0);
      check("stop_busy", busy, 0);
      check("stop_frame_count", frame_count, exp_frames);
      wait_to(s + 45);

      check("fire_q_left", fire_q.size(), 0);
      check("frame_q_left", frame_q.size(), 0);
      check("wr_q_left", wr_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
